// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the SRAM controller.
//   state_t     : controller FSM states
//   SRAM_ADDR_W : off-chip halfword address width
//   SRAM_DATA_W : off-chip data width
//   half_addr() : word index + half select -> halfword address
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [SRAM_ADDR_W-1:0] half_addr(
        input logic [WORD_IDX_W-1:0] word,
        input logic                  half
    );
        return {word, half};
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if
// Memory-stage request bus between the pipeline (master) and the SRAM
// controller (slave).
//   read, write      : word request, held while SRAM_NOT_READY is high
//   address          : byte address, bits [18:2] select the word
//   writedata        : store data
//   readdata         : load data, valid in the release cycle
//   SRAM_NOT_READY   : stall, high while the request is unfinished
// ---------------------------------------------------------------------------
interface sram_ctrl_if;

    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        SRAM_NOT_READY;

    modport master (
        output read, write, address, writedata,
        input  readdata, SRAM_NOT_READY
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, SRAM_NOT_READY
    );

endinterface

// File: rtl/sram_ctrl_phase_timer.sv
// ---------------------------------------------------------------------------
// sram_phase_timer
// Per-phase cycle counter. Runs 0..WAIT_CYCLES while i_run is high and
// flags the terminal count; wraps to 0 at terminal count so the next phase
// starts fresh, and is held at 0 while i_run is low.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_run          : high during an SRAM phase
//   o_tc           : terminal count of the current phase
// ---------------------------------------------------------------------------
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_tc
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = i_run && (r_cnt == CNT_W'(WAIT_CYCLES));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (!i_run || o_tc)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Splits each 32-bit word request into two 16-bit SRAM accesses, low half
// first, stalling the pipeline until the release (DONE) cycle.
//   i_clk, i_rst_n   : clock, async active-low reset
//   bus              : memory-stage request bus (sram_ctrl_if.slave)
//   o_SRAMaddress    : halfword address {word, half}
//   o_SRAMWEn        : write enable, active-low
//   o_SRAMOE         : output enable, active-low
//   io_SRAMdata      : bidirectional data, driven only in write phases
// Optional feature: SRAM_CTRL_HIT_BYPASS_EN adds a one-entry last-word
// register that answers matching reads in IDLE without an SRAM access.
//
// state | meaning
// IDLE  | waiting; a request is captured here (this cycle stalls)
// LO    | low halfword access, WAIT_CYCLES+1 cycles
// HI    | high halfword access, WAIT_CYCLES+1 cycles
// DONE  | release cycle, stall low, readdata valid
// ---------------------------------------------------------------------------
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    sram_ctrl_if.slave             bus,
    output logic [SRAM_ADDR_W-1:0] o_SRAMaddress,
    output logic                   o_SRAMWEn,
    output logic                   o_SRAMOE,
    inout  wire  [SRAM_DATA_W-1:0] io_SRAMdata
);

    state_t                   r_state;
    state_t                   w_next;
    logic [WORD_IDX_W-1:0]    r_word;
    logic [31:0]              r_wdata;
    logic                     r_is_write;
    logic [SRAM_DATA_W-1:0]   r_lo;
    logic [31:0]              r_rdata;
    logic [SRAM_ADDR_W-1:0]   r_sram_addr;
    logic                     w_req;
    logic                     w_tc;
    logic                     w_phase;
    logic                     w_start;
    logic                     w_hit;

    assign w_req   = bus.read | bus.write;
    assign w_phase = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_start = (r_state == ST_IDLE) && w_req && !w_hit;

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (w_phase),
        .o_tc    (w_tc)
    );

`ifdef SRAM_CTRL_HIT_BYPASS_EN
    logic                  r_byp_valid;
    logic [WORD_IDX_W-1:0] r_byp_word;
    logic [31:0]           r_byp_data;

    // A simultaneous read+write is a write, so it never takes the hit path.
    assign w_hit = r_byp_valid && bus.read && !bus.write &&
                   (r_state == ST_IDLE) && (bus.address[18:2] == r_byp_word);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byp_valid <= 1'b0;
            r_byp_word  <= '0;
            r_byp_data  <= '0;
        end else if (r_state == ST_HI && w_tc) begin
            r_byp_valid <= 1'b1;
            r_byp_word  <= r_word;
            r_byp_data  <= r_is_write ? r_wdata : {io_SRAMdata, r_lo};
        end
    end

    assign bus.readdata = w_hit ? r_byp_data : r_rdata;
`else
    assign w_hit        = 1'b0;
    assign bus.readdata = r_rdata;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_LO;
            ST_LO:   if (w_tc)    w_next = ST_HI;
            ST_HI:   if (w_tc)    w_next = ST_DONE;
            ST_DONE:              w_next = ST_IDLE;
            default:              w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // The SRAM address is a register so it only moves on phase boundaries
    // and never follows the live request inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_lo        <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
        end else begin
            if (w_start) begin
                r_word      <= bus.address[18:2];
                r_wdata     <= bus.writedata;
                r_is_write  <= bus.write;
                r_sram_addr <= half_addr(bus.address[18:2], 1'b0);
            end
            if (r_state == ST_LO && w_tc) begin
                r_sram_addr <= half_addr(r_word, 1'b1);
                if (!r_is_write)
                    r_lo <= io_SRAMdata;
            end
            if (r_state == ST_HI && w_tc && !r_is_write)
                r_rdata <= {io_SRAMdata, r_lo};
        end
    end

    assign bus.SRAM_NOT_READY = w_req && (r_state != ST_DONE) && !w_hit;

    assign o_SRAMaddress = r_sram_addr;
    assign o_SRAMWEn     = !(w_phase && r_is_write);
    assign o_SRAMOE      = !(w_phase && !r_is_write);
    assign io_SRAMdata   = !o_SRAMWEn ?
                           ((r_state == ST_HI) ? r_wdata[31:16] : r_wdata[15:0]) :
                           {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl (WAIT_CYCLES = 1) with a small SRAM model.
// The bus probe drives 0x5A5A onto the data pins where the controller is
// expected to have released them.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        preload = 1'b1;
    logic        probe_en = 1'b0;

    logic [17:0] sram_addr;
    logic        sram_wen;
    logic        sram_oe;
    wire  [15:0] sram_data;
    logic [15:0] mem [0:1023];

    int          n_checks = 0;
    int          n_errors = 0;
    int          stall;
    int          oe_lo;
    int          wen_lo;
    logic [17:0] t_addr [0:15];
    logic        t_wen  [0:15];
    logic [15:0] t_data [0:15];

    always #5 clk = ~clk;

    sram_ctrl_if bus ();

    sram_ctrl #(
        .WAIT_CYCLES (WC)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .bus           (bus),
        .o_SRAMaddress (sram_addr),
        .o_SRAMWEn     (sram_wen),
        .o_SRAMOE      (sram_oe),
        .io_SRAMdata   (sram_data)
    );

    assign sram_data = probe_en ? 16'h5A5A :
                       ((!sram_oe && sram_wen) ? mem[sram_addr[9:0]] : 16'hzzzz);

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h204] <= 16'h1234;
            mem[10'h205] <= 16'hABCD;
        end else if (!sram_wen) begin
            mem[sram_addr[9:0]] <= sram_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.read      = r;
        bus.write     = w;
        bus.address   = a;
        bus.writedata = d;
    endtask

    // Samples the current cycle onward until the stall drops; ends in the
    // release cycle.
    task automatic run_txn();
        int k;
        k      = 0;
        stall  = 0;
        oe_lo  = 0;
        wen_lo = 0;
        while (bus.SRAM_NOT_READY && k < 40) begin
            stall++;
            if (!sram_oe)  oe_lo++;
            if (!sram_wen) wen_lo++;
            if (k < 16) begin
                t_addr[k] = sram_addr;
                t_wen[k]  = sram_wen;
                t_data[k] = sram_data;
            end
            k++;
            cyc();
        end
        chk("txn_bound", {31'b0, bus.SRAM_NOT_READY}, 32'd0);
    endtask

    initial begin
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) cyc();
        preload = 1'b0;
        rst_n   = 1'b1;
        cyc();

        // reset state
        probe_en = 1'b1;
        #1;
        chk("rst_nrdy",  {31'b0, bus.SRAM_NOT_READY}, 32'd0);
        chk("rst_rdata", bus.readdata, 32'h0);
        chk("rst_addr",  {14'b0, sram_addr}, 32'h0);
        chk("rst_wen",   {31'b0, sram_wen}, 32'd1);
        chk("rst_oe",    {31'b0, sram_oe}, 32'd1);
        chk("rst_bus",   {16'b0, sram_data}, 32'h5A5A);
        probe_en = 1'b0;

        // read 0x408
        set_req(1'b1, 1'b0, 32'h0000_0408, 32'h0);
        #1;
        run_txn();
        chk("rd_stall",   stall, 32'd5);
        chk("rd_oe_lo",   oe_lo, 32'd4);
        chk("rd_wen_lo",  wen_lo, 32'd0);
        chk("rd_addr_lo", {14'b0, t_addr[1]}, 32'h204);
        chk("rd_addr_hi", {14'b0, t_addr[3]}, 32'h205);
        chk("rd_data",    bus.readdata, 32'hABCD_1234);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("rd_hold",    bus.readdata, 32'hABCD_1234);
        chk("idle_nrdy",  {31'b0, bus.SRAM_NOT_READY}, 32'd0);

        // write 0xDEADBEEF to 0x40C
        set_req(1'b0, 1'b1, 32'h0000_040C, 32'hDEAD_BEEF);
        #1;
        run_txn();
        chk("wr_stall",   stall, 32'd5);
        chk("wr_wen_lo",  wen_lo, 32'd4);
        chk("wr_oe_lo",   oe_lo, 32'd0);
        chk("wr_idle_wen",{31'b0, t_wen[0]}, 32'd1);
        chk("wr_a1",      {14'b0, t_addr[1]}, 32'h206);
        chk("wr_d1",      {16'b0, t_data[1]}, 32'hBEEF);
        chk("wr_a2",      {14'b0, t_addr[2]}, 32'h206);
        chk("wr_w2",      {31'b0, t_wen[2]}, 32'd0);
        chk("wr_a3",      {14'b0, t_addr[3]}, 32'h207);
        chk("wr_d3",      {16'b0, t_data[3]}, 32'hDEAD);
        chk("wr_d4",      {16'b0, t_data[4]}, 32'hDEAD);
        chk("wr_rd_hold", bus.readdata, 32'hABCD_1234);

        // back-to-back read of the same word
        set_req(1'b1, 1'b0, 32'h0000_040C, 32'h0);
        cyc();
`ifdef SRAM_CTRL_HIT_BYPASS_EN
        chk("hit_nrdy",  {31'b0, bus.SRAM_NOT_READY}, 32'd0);
        chk("hit_data",  bus.readdata, 32'hDEAD_BEEF);
        chk("hit_oe",    {31'b0, sram_oe}, 32'd1);
        chk("hit_wen",   {31'b0, sram_wen}, 32'd1);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("hit_noacc", {31'b0, sram_oe}, 32'd1);
`else
        chk("gap_nrdy",  {31'b0, bus.SRAM_NOT_READY}, 32'd1);
        chk("gap_oe",    {31'b0, sram_oe}, 32'd1);
        chk("gap_wen",   {31'b0, sram_wen}, 32'd1);
        run_txn();
        chk("b2b_stall", stall, 32'd5);
        chk("b2b_oe_lo", oe_lo, 32'd4);
        chk("b2b_data",  bus.readdata, 32'hDEAD_BEEF);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
`endif

        // read and write both high -> write
        set_req(1'b1, 1'b1, 32'h0000_0410, 32'h0BAD_F00D);
        #1;
        run_txn();
        chk("both_stall", stall, 32'd5);
        chk("both_oe_lo", oe_lo, 32'd0);
        chk("both_wen",   wen_lo, 32'd4);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("both_mem_lo", {16'b0, mem[10'h208]}, 32'hF00D);
        chk("both_mem_hi", {16'b0, mem[10'h209]}, 32'h0BAD);

        // reset asserted during the HI phase of a write
        set_req(1'b0, 1'b1, 32'h0000_0414, 32'h1234_5678);
        #1;
        cyc();
        cyc();
        cyc();
        chk("mr_in_hi_wen",  {31'b0, sram_wen}, 32'd0);
        chk("mr_in_hi_addr", {14'b0, sram_addr}, 32'h20B);
        #1;
        rst_n    = 1'b0;
        probe_en = 1'b1;
        #1;
        chk("mr_wen",   {31'b0, sram_wen}, 32'd1);
        chk("mr_oe",    {31'b0, sram_oe}, 32'd1);
        chk("mr_rdata", bus.readdata, 32'h0);
        chk("mr_addr",  {14'b0, sram_addr}, 32'h0);
        chk("mr_bus",   {16'b0, sram_data}, 32'h5A5A);
        probe_en = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mr_abandon", {16'b0, mem[10'h20B]}, 32'h0);

        // controller is back in IDLE: a fresh read takes the full stall
        set_req(1'b1, 1'b0, 32'h0000_0408, 32'h0);
        #1;
        run_txn();
        chk("post_rst_stall", stall, 32'd5);
        chk("post_rst_data",  bus.readdata, 32'hABCD_1234);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
